// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states,
// default data width and small op-decoding helpers.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Signed ops have a clear low op bit; divides have the high op bit set.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Controller-to-MDU bundle: launch/move requests in, HI/LO and status back out.
interface mult_div_unit_if #(
  parameter int DATA_W = mult_div_unit_pkg::DATA_W
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned datapath: one shift-add (multiply) or restoring trial-subtract (divide)
// step per enabled cycle on an {upper, lower} register pair.
module mdu_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [DATA_W-1:0] lower_init,
  input  logic [DATA_W-1:0] m_init,
  output logic [DATA_W-1:0] upper,
  output logic [DATA_W-1:0] lower
);

  logic [DATA_W-1:0] upper_q, lower_q, m_q;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              keep;

  always_comb begin
    add_sum = {1'b0, upper_q} + (lower_q[0] ? {1'b0, m_q} : '0);
    rem_sh  = {upper_q, lower_q[DATA_W-1]};
    keep    = (rem_sh >= {1'b0, m_q});
    // Only used when keep is set, where the true difference is below m_q.
    diff    = rem_sh[DATA_W-1:0] - m_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upper_q <= '0;
      lower_q <= '0;
      m_q     <= '0;
    end else if (load) begin
      upper_q <= '0;
      lower_q <= lower_init;
      m_q     <= m_init;
    end else if (step) begin
      if (div_mode) begin
        upper_q <= keep ? diff : rem_sh[DATA_W-1:0];
        lower_q <= {lower_q[DATA_W-2:0], keep};
      end else begin
        {upper_q, lower_q} <= {add_sum, lower_q[DATA_W-1:1]};
      end
    end
  end

  assign upper = upper_q;
  assign lower = lower_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO: sign handling,
// FSM, iteration counter and MTHI/MTLO around the unsigned iteration core.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_W = mult_div_unit_pkg::DATA_W
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              done_q;
  logic              busy;
  logic              is_div_q, neg_main_q, neg_rem_q, div_zero_q;

  logic              accept, in_signed, in_div;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] core_upper, core_lower;
  logic [2*DATA_W-1:0] product, product_fix;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  assign in_signed = op_is_signed(bus.op);
  assign in_div    = op_is_div(bus.op);
  assign accept    = (state_q == MD_IDLE) && bus.start;
  assign a_mag     = (in_signed && bus.operand_a[DATA_W-1]) ? -bus.operand_a : bus.operand_a;
  assign b_mag     = (in_signed && bus.operand_b[DATA_W-1]) ? -bus.operand_b : bus.operand_b;

  // Multiply iterates over the multiplier in lower; divide shifts the dividend out of lower.
  mdu_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       (state_q == MD_RUN),
    .div_mode   (is_div_q),
    .lower_init (in_div ? a_mag : b_mag),
    .m_init     (in_div ? b_mag : a_mag),
    .upper      (core_upper),
    .lower      (core_lower)
  );

  // Divide by zero keeps the all-ones quotient; the remainder negation restores operand_a.
  always_comb begin
    product     = {core_upper, core_lower};
    product_fix = neg_main_q ? -product : product;
    quot_fix    = (neg_main_q && !div_zero_q) ? -core_lower : core_lower;
    rem_fix     = neg_rem_q ? -core_upper : core_upper;
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      MD_IDLE: if (bus.start) state_d = MD_RUN;
      MD_RUN: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = MD_FIX;
      end
      MD_FIX: begin
        busy    = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == MD_FIX);

      if (accept) begin
        count_q    <= '0;
        is_div_q   <= in_div;
        neg_main_q <= in_signed && (bus.operand_a[DATA_W-1] ^ bus.operand_b[DATA_W-1]);
        neg_rem_q  <= in_signed && bus.operand_a[DATA_W-1];
        div_zero_q <= (bus.operand_b == '0);
      end else if (state_q == MD_RUN) begin
        count_q <= count_q + 1'b1;
      end

      if (state_q == MD_IDLE) begin
        if (bus.mthi) hi_q <= bus.operand_a;
        if (bus.mtlo) lo_q <= bus.operand_a;
      end else if (state_q == MD_FIX) begin
        if (is_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end else begin
          {hi_q, lo_q} <= product_fix;
        end
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule
